video_frame_sequencer: RTL and testbench

VIDEO_FRAME_SEQUENCER -- requirements
Module: video_frame_sequencer

---
 rtl/video_frame_sequencer.sv | 170 +++++++++++++++++
 tb/tb_video_frame_sequencer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/video_frame_sequencer.sv
// Frames an unframed pixel beat stream into AXI4-Stream video (tuser = SOF, tlast = EOL).
// Optional VIDEO_FRAME_SEQUENCER_UNDERRUN_CNT_EN adds a saturating source-underrun cycle counter.
module video_frame_sequencer #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 12
) (
  input  logic              aclk,
  input  logic              reset,
  input  logic              enable,
  input  logic [CNT_W-1:0]  hsize,
  input  logic [CNT_W-1:0]  vsize,
  input  logic [DATA_W-1:0] src_tdata,
  input  logic              src_tvalid,
  output logic              src_tready,
  output logic [DATA_W-1:0] m_axis_vid_tdata,
  output logic              m_axis_vid_tvalid,
  input  logic              m_axis_vid_tready,
  output logic              m_axis_vid_tuser,
  output logic              m_axis_vid_tlast,
  output logic              frame_done,
  output logic              busy
`ifdef VIDEO_FRAME_SEQUENCER_UNDERRUN_CNT_EN
  ,
  output logic [15:0]       underrun_count
`endif
);

  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    x_q, x_d;
  logic [CNT_W-1:0]    y_q, y_d;
  logic [CNT_W-1:0]    hs_q, hs_d;
  logic [CNT_W-1:0]    vs_q, vs_d;
  logic [DATA_W-1:0]   tdata_q, tdata_d;
  logic                tvalid_q, tvalid_d;
  logic                tuser_q, tuser_d;
  logic                tlast_q, tlast_d;
  logic                frame_done_q, frame_done_d;

  logic                sizes_ok;
  logic                out_free;
  logic                accept;
  logic                x_last;
  logic                y_last;

  assign sizes_ok = enable && (hsize != '0) && (vsize != '0);
  assign out_free = !tvalid_q || m_axis_vid_tready;
  assign accept   = src_tvalid && src_tready;
  assign x_last   = (x_q == hs_q - 1'b1);
  assign y_last   = (y_q == vs_q - 1'b1);

  assign src_tready        = (state_q == ACTIVE) && out_free;
  assign m_axis_vid_tdata  = tdata_q;
  assign m_axis_vid_tvalid = tvalid_q;
  assign m_axis_vid_tuser  = tuser_q;
  assign m_axis_vid_tlast  = tlast_q;
  assign frame_done        = frame_done_q;
  assign busy              = (state_q != IDLE);

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    hs_d         = hs_q;
    vs_d         = vs_q;
    tdata_d      = tdata_q;
    tvalid_d     = tvalid_q;
    tuser_d      = tuser_q;
    tlast_d      = tlast_q;
    frame_done_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (sizes_ok) begin
          hs_d    = hsize;
          vs_d    = vsize;
          x_d     = '0;
          y_d     = '0;
          state_d = ACTIVE;
        end
      end

      ACTIVE: begin
        if (accept) begin
          tdata_d  = src_tdata;
          tvalid_d = 1'b1;
          tuser_d  = (x_q == '0) && (y_q == '0);
          tlast_d  = x_last;
          if (x_last) begin
            x_d = '0;
            if (y_last) begin
              y_d     = '0;
              state_d = DRAIN;
            end else begin
              y_d = y_q + 1'b1;
            end
          end else begin
            x_d = x_q + 1'b1;
          end
        end else if (m_axis_vid_tready) begin
          tvalid_d = 1'b0;
        end
      end

      DRAIN: begin
        if (m_axis_vid_tready) tvalid_d = 1'b0;
        // frame_done fires once the final beat has left the output register
        if (out_free) begin
          frame_done_d = 1'b1;
          if (sizes_ok) begin
            hs_d    = hsize;
            vs_d    = vsize;
            x_d     = '0;
            y_d     = '0;
            state_d = ACTIVE;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      state_q      <= IDLE;
      x_q          <= '0;
      y_q          <= '0;
      hs_q         <= '0;
      vs_q         <= '0;
      tdata_q      <= '0;
      tvalid_q     <= 1'b0;
      tuser_q      <= 1'b0;
      tlast_q      <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      hs_q         <= hs_d;
      vs_q         <= vs_d;
      tdata_q      <= tdata_d;
      tvalid_q     <= tvalid_d;
      tuser_q      <= tuser_d;
      tlast_q      <= tlast_d;
      frame_done_q <= frame_done_d;
    end
  end

`ifdef VIDEO_FRAME_SEQUENCER_UNDERRUN_CNT_EN
  logic [15:0] underrun_q, underrun_d;

  always_comb begin
    underrun_d = underrun_q;
    if ((state_q == ACTIVE) && out_free && !src_tvalid && (underrun_q != '1))
      underrun_d = underrun_q + 1'b1;
  end

  always_ff @(posedge aclk) begin
    if (reset) underrun_q <= '0;
    else       underrun_q <= underrun_d;
  end

  assign underrun_count = underrun_q;
`endif

endmodule

// File: tb/tb_video_frame_sequencer.sv
// Randomized bench for video_frame_sequencer against a beat-index frame model.
module tb_video_frame_sequencer;

  logic        aclk = 1'b0;
  logic        reset;
  logic        enable;
  logic [11:0] hsize;
  logic [11:0] vsize;
  logic [31:0] src_tdata;
  logic        src_tvalid;
  logic        src_tready;
  logic [31:0] m_axis_vid_tdata;
  logic        m_axis_vid_tvalid;
  logic        m_axis_vid_tready;
  logic        m_axis_vid_tuser;
  logic        m_axis_vid_tlast;
  logic        frame_done;
  logic        busy;
`ifdef VIDEO_FRAME_SEQUENCER_UNDERRUN_CNT_EN
  logic [15:0] underrun_count;
`endif

  video_frame_sequencer #(.DATA_W(32), .CNT_W(12)) dut (
    .aclk              (aclk),
    .reset             (reset),
    .enable            (enable),
    .hsize             (hsize),
    .vsize             (vsize),
    .src_tdata         (src_tdata),
    .src_tvalid        (src_tvalid),
    .src_tready        (src_tready),
    .m_axis_vid_tdata  (m_axis_vid_tdata),
    .m_axis_vid_tvalid (m_axis_vid_tvalid),
    .m_axis_vid_tready (m_axis_vid_tready),
    .m_axis_vid_tuser  (m_axis_vid_tuser),
    .m_axis_vid_tlast  (m_axis_vid_tlast),
    .frame_done        (frame_done),
    .busy              (busy)
`ifdef VIDEO_FRAME_SEQUENCER_UNDERRUN_CNT_EN
    ,
    .underrun_count    (underrun_count)
`endif
  );

  always #5 aclk = ~aclk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Reference: mode 0 idle, 1 streaming a frame, 2 waiting for last beat to leave.
  // Position within a frame is a single beat index; x/y follow by division.
  int          m_mode = 0;
  int          m_n    = 0;
  int          m_fh   = 0;
  int          m_fv   = 0;
  bit          m_ov   = 0;
  logic [31:0] m_od   = '0;
  bit          m_ou   = 0;
  bit          m_ol   = 0;
  bit          m_fd   = 0;
  int          m_uc   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit rst, input bit en, input int hs, input int vs,
                            input bit sv, input logic [31:0] sd, input bit tr);
    bit free;
    bit ok;
    if (rst) begin
      m_mode = 0; m_n = 0; m_fh = 0; m_fv = 0;
      m_ov = 0; m_od = '0; m_ou = 0; m_ol = 0; m_fd = 0; m_uc = 0;
      return;
    end
    free = !m_ov || tr;
    ok   = en && hs != 0 && vs != 0;
    m_fd = 0;
    if (m_mode == 1 && free && !sv && m_uc != 16'hFFFF) m_uc++;
    case (m_mode)
      0: if (ok) begin m_fh = hs; m_fv = vs; m_n = 0; m_mode = 1; end
      1: begin
        if (free && sv) begin
          m_od = sd; m_ov = 1;
          m_ou = (m_n == 0);
          m_ol = ((m_n % m_fh) == m_fh - 1);
          m_n++;
          if (m_n == m_fh * m_fv) m_mode = 2;
        end else if (tr) begin
          m_ov = 0;
        end
      end
      default: begin
        if (m_ov && tr) m_ov = 0;
        if (free) begin
          m_fd = 1;
          if (ok) begin m_fh = hs; m_fv = vs; m_n = 0; m_mode = 1; end
          else m_mode = 0;
        end
      end
    endcase
  endtask

  // One clock: drive at negedge, compare DUT to model state, then advance the model.
  task automatic cycle(input bit rst, input bit en, input int hs, input int vs,
                       input bit sv, input bit tr);
    logic [31:0] sd;
    sd = $urandom;
    @(negedge aclk);
    reset = rst; enable = en; hsize = 12'(hs); vsize = 12'(vs);
    src_tvalid = sv; src_tdata = sd; m_axis_vid_tready = tr;
    #1;
    check("tvalid",     32'(m_axis_vid_tvalid), 32'(m_ov));
    check("tdata",      m_axis_vid_tdata,       m_od);
    check("tuser",      32'(m_axis_vid_tuser),  32'(m_ou));
    check("tlast",      32'(m_axis_vid_tlast),  32'(m_ol));
    check("frame_done", 32'(frame_done),        32'(m_fd));
    check("busy",       32'(busy),              32'(m_mode != 0));
    check("src_tready", 32'(src_tready),        32'(m_mode == 1 && (!m_ov || tr)));
`ifdef VIDEO_FRAME_SEQUENCER_UNDERRUN_CNT_EN
    check("underrun",   32'(underrun_count),    32'(m_uc));
`endif
    model_step(rst, en, hs, vs, sv, sd, tr);
  endtask

  int hs_r;
  int vs_r;
  int hs_set[6] = '{0, 1, 2, 3, 4, 8};

  initial begin
    reset = 1'b1; enable = 1'b0; hsize = '0; vsize = '0;
    src_tdata = '0; src_tvalid = 1'b0; m_axis_vid_tready = 1'b0;
    repeat (3) @(posedge aclk);
    model_step(1, 0, 0, 0, 0, '0, 0);

    // reset state, then a 4x2 frame stream with everything always ready
    for (int i = 0; i < 24; i++) cycle(0, 1, 4, 2, 1, 1);

    // output stalls and source gaps
    for (int i = 0; i < 300; i++)
      cycle(0, 1, 4, 2, $urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7);

    // three-cycle stall mid-line
    for (int i = 0; i < 3; i++) cycle(0, 1, 4, 2, 1, 0);
    for (int i = 0; i < 10; i++) cycle(0, 1, 4, 2, 1, 1);

    // five free cycles with no source data
    for (int i = 0; i < 5; i++) cycle(0, 1, 4, 2, 0, 1);
    for (int i = 0; i < 10; i++) cycle(0, 1, 4, 2, 1, 1);

    // size change mid-frame takes effect on the next frame only
    for (int i = 0; i < 3; i++) cycle(0, 1, 4, 2, 1, 1);
    for (int i = 0; i < 40; i++) cycle(0, 1, 8, 2, 1, 1);

    // random size changes, enable drops and flow control
    hs_r = 4; vs_r = 2;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        hs_r = hs_set[$urandom_range(0, 5)];
        vs_r = $urandom_range(0, 3);
      end
      cycle(0, $urandom_range(0, 9) != 0, hs_r, vs_r,
            $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
    end

    // enable dropped mid-frame: frame completes, then idle
    for (int i = 0; i < 6; i++) cycle(0, 1, 4, 2, 1, 1);
    for (int i = 0; i < 40; i++) cycle(0, 0, 4, 2, 1, $urandom_range(0, 1));

    // zero hsize: never starts
    for (int i = 0; i < 30; i++) cycle(0, 1, 0, 2, 1, 1);
    for (int i = 0; i < 10; i++) cycle(0, 1, 4, 0, 1, 1);

    // reset at beat 5, restart with SOF
    for (int i = 0; i < 7; i++) cycle(0, 1, 4, 2, 1, 1);
    cycle(1, 1, 4, 2, 1, 1);
    for (int i = 0; i < 20; i++) cycle(0, 1, 4, 2, 1, 1);

    // random resets throughout
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 24) == 0) begin
        hs_r = hs_set[$urandom_range(0, 5)];
        vs_r = $urandom_range(0, 3);
      end
      cycle($urandom_range(0, 39) == 0, $urandom_range(0, 7) != 0, hs_r, vs_r,
            $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
